// File: rtl/calc_pkg.sv
// Shared calculator definitions: command codes driven from the keypad to
// calc_top, the (row,col) -> command key map, and small row-decode helpers.
package calc_pkg;

  typedef enum logic [3:0] {
    CMD_0    = 4'd0,
    CMD_1    = 4'd1,
    CMD_2    = 4'd2,
    CMD_3    = 4'd3,
    CMD_4    = 4'd4,
    CMD_5    = 4'd5,
    CMD_6    = 4'd6,
    CMD_7    = 4'd7,
    CMD_8    = 4'd8,
    CMD_9    = 4'd9,
    CMD_ADD  = 4'd10,
    CMD_SUB  = 4'd11,
    CMD_MUL  = 4'd12,
    CMD_EQ   = 4'd13,
    CMD_CLR  = 4'd14,
    CMD_IDLE = 4'd15
  } cmd_t;

  // Indexed KEY_MAP[row][col]; leftmost group is row 3, leftmost entry col 3.
  // Key (3,3) is inert and maps to CMD_IDLE.
  localparam logic [3:0][3:0][3:0] KEY_MAP = {
    {CMD_IDLE, CMD_EQ, CMD_0,   CMD_CLR},
    {CMD_MUL,  CMD_9,  CMD_8,   CMD_7  },
    {CMD_SUB,  CMD_6,  CMD_5,   CMD_4  },
    {CMD_ADD,  CMD_3,  CMD_2,   CMD_1  }
  };

  // True when exactly one active-low row line is asserted.
  function automatic logic one_row_low(input logic [3:0] rows);
    return ($countones(~rows) == 1);
  endfunction

  // Index of the lowest-numbered low row (meaningful when one_row_low holds).
  function automatic logic [1:0] low_row_idx(input logic [3:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/row_sync.sv
// Two-flop synchronizer for the asynchronous active-low keypad row lines.
// Ports: clock_i, reset_i (sync, active-high), rows_i (raw), rows_o (synchronized).
module row_sync (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic [3:0] rows_i,
  output logic [3:0] rows_o
);

  logic [3:0] meta_q;
  logic [3:0] sync_q;

  // Idle rows read high, so both stages reset to all ones.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      meta_q <= 4'b1111;
      sync_q <= 4'b1111;
    end else begin
      meta_q <= rows_i;
      sync_q <= meta_q;
    end
  end

  assign rows_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks an active-low column strobe, debounces a
// single-key press, emits one registered command pulse, then waits for a
// debounced release before scanning again.
// Ports: clock, reset (sync, active-high), rows_in (raw active-low rows),
//        cols_out (active-low column drive, one bit low), cmd (command code,
//        CMD_IDLE except during a one-cycle key pulse).
module keypad_scanner
  import calc_pkg::*;
#(
  parameter int unsigned SCAN_DIV        = 1000,
  parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] rows_in,
  output logic [3:0] cols_out,
  output logic [3:0] cmd
);

  localparam int unsigned MAX_CNT = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_EMIT,
    ST_WAIT_RELEASE
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       col_q, col_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       row_q, row_d;
  logic [3:0]       pat_q, pat_d;
  cmd_t             cmd_q, cmd_d;
  logic [3:0]       cols_q, cols_d;
  logic [3:0]       rows_s;

  row_sync u_row_sync (
    .clock_i (clock),
    .reset_i (reset),
    .rows_i  (rows_in),
    .rows_o  (rows_s)
  );

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_SCAN;
      col_q   <= 2'd0;
      cnt_q   <= '0;
      row_q   <= 2'd0;
      pat_q   <= 4'b1111;
      cmd_q   <= CMD_IDLE;
      cols_q  <= 4'b1110;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      pat_q   <= pat_d;
      cmd_q   <= cmd_d;
      cols_q  <= cols_d;
    end
  end

  // Next-state logic; one counter serves column dwell, debounce and release.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    pat_d   = pat_q;
    unique case (state_q)
      ST_SCAN: begin
        if (cnt_q == SCAN_LAST) begin
          cnt_d = '0;
          if (one_row_low(rows_s)) begin
            // Keep the column so debounce sees the same key.
            state_d = ST_DEBOUNCE;
            row_d   = low_row_idx(rows_s);
            pat_d   = rows_s;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DEBOUNCE: begin
        if (rows_s != pat_q) begin
          state_d = ST_SCAN;
          col_d   = col_q + 2'd1;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = ST_EMIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_EMIT: begin
        state_d = ST_WAIT_RELEASE;
        cnt_d   = '0;
      end
      ST_WAIT_RELEASE: begin
        if (rows_s != 4'b1111) begin
          cnt_d = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = ST_SCAN;
          col_d   = col_q + 2'd1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_SCAN;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from the next state so cmd/cols_out land in registers
  // aligned with the state they belong to.
  always_comb begin
    cmd_d  = CMD_IDLE;
    cols_d = ~(4'b0001 << col_d);
    if (state_d == ST_EMIT) begin
      cmd_d = cmd_t'(KEY_MAP[row_q][col_q]);
    end
  end

  assign cols_out = cols_q;
  assign cmd      = cmd_q;

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

  logic       clock;
  logic       reset;
  logic [3:0] rows_in;
  logic [3:0] cols_out;
  logic [3:0] cmd;

  // Pressed keys, bit index = row*4 + col.
  logic [15:0] keys;

  int n_cmp;
  int n_err;

  keypad_scanner #(
    .SCAN_DIV        (4),
    .DEBOUNCE_CYCLES (8)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .rows_in  (rows_in),
    .cols_out (cols_out),
    .cmd      (cmd)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Switch matrix: a row reads low when a pressed key joins it to a driven column.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      rows_in[r] = ~|(keys[r*4 +: 4] & ~cols_out);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    keys  = '0;
    repeat (4) tick();
    chk("reset_cols", 32'(cols_out), 32'h0000_000E);
    chk("reset_cmd", 32'(cmd), 32'h0000_000F);
    reset = 1'b0;
  endtask

  // Run n cycles, counting cycles with a non-idle cmd and checking the column strobe.
  task automatic watch(input int n, output int pulses, output logic [3:0] code, output int first);
    pulses = 0;
    code   = 4'hF;
    first  = -1;
    for (int i = 0; i < n; i++) begin
      tick();
      chk("cols_onehot", 32'($countones(~cols_out)), 32'd1);
      if (cmd !== 4'hF) begin
        if (pulses == 0) first = i;
        pulses++;
        code = cmd;
      end
    end
  endtask

  initial begin
    int         pulses;
    logic [3:0] code;
    int         first;

    n_cmp   = 0;
    n_err   = 0;
    reset   = 1'b1;
    keys    = '0;

    // Scenario 1: column rotation after reset, 4 cycles per column.
    do_reset();
    for (int i = 0; i < 19; i++) begin
      logic [3:0] exp_cols;
      tick();
      exp_cols = ~(4'b0001 << (((i + 1) / 4) % 4));
      chk("s1_cols", 32'(cols_out), 32'(exp_cols));
      chk("s1_cmd", 32'(cmd), 32'h0000_000F);
    end

    // Scenario 2: key (1,1) held 40 cycles -> one cycle of cmd 5.
    do_reset();
    keys[1*4 + 1] = 1'b1;
    watch(40, pulses, code, first);
    chk("s2_pulses", 32'(pulses), 32'd1);
    chk("s2_code", 32'(code), 32'd5);
    chk("s2_pulse_cycle", 32'(first), 32'd15);
    chk("s2_latency_ok", 32'(first <= 27), 32'd1);
    keys = '0;
    tick();
    chk("s2_idle_after", 32'(cmd), 32'h0000_000F);

    // Scenario 3: bouncing (0,3) never settles -> no pulse.
    do_reset();
    pulses = 0;
    for (int i = 0; i < 120; i++) begin
      keys[0*4 + 3] = ((i % 4) != 3);
      tick();
      if (cmd !== 4'hF) pulses++;
    end
    chk("s3_pulses", 32'(pulses), 32'd0);
    keys = '0;

    // Scenario 4: two keys sharing column 2 -> rejected; release (0,2) -> cmd 13.
    do_reset();
    keys[0*4 + 2] = 1'b1;
    keys[3*4 + 2] = 1'b1;
    watch(60, pulses, code, first);
    chk("s4_dual_pulses", 32'(pulses), 32'd0);
    keys[0*4 + 2] = 1'b0;
    watch(40, pulses, code, first);
    chk("s4_pulses", 32'(pulses), 32'd1);
    chk("s4_code", 32'(code), 32'd13);
    keys = '0;

    // Scenario 5: hold (2,0) 200 cycles -> one cmd 7; release resumes at column 1.
    do_reset();
    keys[2*4 + 0] = 1'b1;
    watch(200, pulses, code, first);
    chk("s5_pulses", 32'(pulses), 32'd1);
    chk("s5_code", 32'(code), 32'd7);
    chk("s5_held_col", 32'(cols_out), 32'h0000_000E);
    keys = '0;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("s5_release_cmd", 32'(cmd), 32'h0000_000F);
    end
    chk("s5_col_before", 32'(cols_out), 32'h0000_000E);
    tick();
    chk("s5_col_resume", 32'(cols_out), 32'h0000_000D);

    // Scenario 6: reset during debounce of (0,0) -> pending key discarded.
    do_reset();
    keys[0*4 + 0] = 1'b1;
    repeat (7) tick();
    chk("s6_debounce_hold", 32'(cols_out), 32'h0000_000E);
    chk("s6_no_early_cmd", 32'(cmd), 32'h0000_000F);
    reset = 1'b1;
    keys  = '0;
    tick();
    chk("s6_reset_cols", 32'(cols_out), 32'h0000_000E);
    chk("s6_reset_cmd", 32'(cmd), 32'h0000_000F);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("s6_post_cmd", 32'(cmd), 32'h0000_000F);
      if (i == 2) chk("s6_col0", 32'(cols_out), 32'h0000_000E);
      if (i == 3) chk("s6_col1", 32'(cols_out), 32'h0000_000D);
    end
    watch(36, pulses, code, first);
    chk("s6_pulses", 32'(pulses), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
